// File: rtl/branch_predict_gshare_if.sv
// Fetch/decode-side signal bundle for the gshare predictor.
// The master modport belongs to the pipeline and the slave modport to the predictor.
interface branch_predict_gshare_if;
   logic [31:0] pcF;
   logic        stallD;
   logic        flushD;
   logic        branchD;
   logic        branch_takeD;
   logic        pred_takeF;
   logic        pred_takeD;
   logic        mispredictD;

   modport master (
      output pcF, stallD, flushD, branchD, branch_takeD,
      input  pred_takeF, pred_takeD, mispredictD
   );

   modport slave (
      input  pcF, stallD, flushD, branchD, branch_takeD,
      output pred_takeF, pred_takeD, mispredictD
   );
endinterface

// File: rtl/branch_predict_gshare.sv
// Gshare direction predictor: a global history register XOR the PC indexes a table of 2-bit counters.
// Define BP_PHT_BYPASS_EN to forward a same-cycle counter update into the fetch-stage prediction.
module branch_predict_gshare #(
   parameter int GHR_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   branch_predict_gshare_if.slave bus
);

   localparam int PHT_N = 1 << GHR_W;

   logic [GHR_W-1:0] r_ghr;
   logic [1:0]       r_pht [PHT_N];
   logic             r_validD;
   logic             r_predD;
   logic [GHR_W-1:0] r_indexD;

   logic [GHR_W-1:0] w_indexF;
   logic             w_update;
   logic [1:0]       w_cntCur;
   logic [1:0]       w_cntNext;
   logic             w_predF;
   logic             w_unusedPc;

   assign w_unusedPc = ^{bus.pcF[31:GHR_W+2], bus.pcF[1:0]};

   assign w_indexF = bus.pcF[GHR_W+1:2] ^ r_ghr;
   assign w_update = bus.branchD & r_validD & ~bus.stallD;
   assign w_cntCur = r_pht[r_indexD];

   // Saturating counter step for the decode-stage entry
   always_comb begin
      w_cntNext = w_cntCur;
      if (bus.branch_takeD) begin
         if (w_cntCur != 2'b11) w_cntNext = w_cntCur + 2'd1;
      end else begin
         if (w_cntCur != 2'b00) w_cntNext = w_cntCur - 2'd1;
      end
   end

`ifdef BP_PHT_BYPASS_EN
   always_comb begin
      w_predF = r_pht[w_indexF][1];
      if (w_update && (w_indexF == r_indexD)) w_predF = w_cntNext[1];
   end
`else
   always_comb begin
      w_predF = r_pht[w_indexF][1];
   end
`endif

   assign bus.pred_takeF  = w_predF;
   assign bus.pred_takeD  = r_predD;
   assign bus.mispredictD = bus.branchD & r_validD & (r_predD != bus.branch_takeD);

   // History and counters move only on a resolved, non-stalled branch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ghr <= '0;
         for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
      end else if (w_update) begin
         r_ghr           <= {r_ghr[GHR_W-2:0], bus.branch_takeD};
         r_pht[r_indexD] <= w_cntNext;
      end
   end

   // F->D pipeline register; flush wins over stall
   always_ff @(posedge clk) begin
      if (rst) begin
         r_validD <= 1'b0;
         r_predD  <= 1'b0;
         r_indexD <= '0;
      end else if (bus.flushD) begin
         r_validD <= 1'b0;
         r_predD  <= 1'b0;
         r_indexD <= '0;
      end else if (!bus.stallD) begin
         r_validD <= 1'b1;
         r_predD  <= w_predF;
         r_indexD <= w_indexF;
      end
   end

endmodule
